// File: rtl/uart_fifo_ctrl.sv
// UART transceiver with TX/RX FIFOs, runtime baud divisor, optional parity,
// internal loopback and per-frame error pulses.
module uart_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int DIV_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DIV_W-1:0]           baud_div,
  input  logic                       parity_en,
  input  logic                       parity_odd,
  input  logic                       loopback,
  input  logic                       tx_en,
  input  logic                       rxd,
  output logic                       txd,
  input  logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic [DATA_W-1:0]          rx_data,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic [$clog2(DEPTH+1)-1:0] tx_level,
  output logic [$clog2(DEPTH+1)-1:0] rx_level,
  output logic                       rx_parity_err,
  output logic                       rx_frame_err,
  output logic                       rx_overrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  function automatic logic par_of(input logic [DATA_W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  // Tick generator; the divisor is latched at each wrap.
  logic [DIV_W-1:0] div_cnt, div_lat;
  logic             tick;
  assign tick = (div_cnt == div_lat - DIV_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      div_lat <= DIV_W'(1);
    end else if (tick) begin
      div_cnt <= '0;
      div_lat <= (baud_div == '0) ? DIV_W'(1) : baud_div;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // TX FIFO
  logic [DATA_W-1:0] tx_mem [DEPTH];
  logic [AW-1:0]     tx_wr, tx_rd;
  logic [LW-1:0]     tx_cnt;
  logic              tx_push, tx_pop, tx_can_pop;
  logic [DATA_W-1:0] tx_head;

  assign tx_ready   = (tx_cnt != LW'(DEPTH));
  assign tx_push    = tx_valid && tx_ready;
  assign tx_level   = tx_cnt;
  assign tx_head    = tx_mem[tx_rd];
  assign tx_can_pop = tx_en && (tx_cnt != '0);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + AW'(1);
      if (tx_pop)  tx_rd <= tx_rd + AW'(1);
      if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + LW'(1);
      else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - LW'(1);
    end
  end

  // TX engine
  tx_state_t         tx_state, tx_state_n;
  logic [3:0]        tx_tcnt, tx_tcnt_n;
  logic [2:0]        tx_bit, tx_bit_n;
  logic              tx_have, tx_have_n, tx_par_en, tx_par_en_n, lb_q, lb_n;
  logic [DATA_W-1:0] tx_sh, tx_sh_n;
  logic              tx_par, tx_par_n, tx_end;

  assign tx_end = tick && (tx_tcnt == 4'd15);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state  <= TX_IDLE;
      tx_tcnt   <= '0;
      tx_bit    <= '0;
      tx_have   <= 1'b0;
      tx_par_en <= 1'b0;
      lb_q      <= 1'b0;
    end else begin
      tx_state  <= tx_state_n;
      tx_tcnt   <= tx_tcnt_n;
      tx_bit    <= tx_bit_n;
      tx_have   <= tx_have_n;
      tx_par_en <= tx_par_en_n;
      lb_q      <= lb_n;
    end
  end

  always_ff @(posedge clk) begin
    tx_sh  <= tx_sh_n;
    tx_par <= tx_par_n;
  end

  always_comb begin
    tx_state_n  = tx_state;
    tx_tcnt_n   = tx_tcnt;
    tx_bit_n    = tx_bit;
    tx_have_n   = tx_have;
    tx_par_en_n = tx_par_en;
    lb_n        = lb_q;
    tx_sh_n     = tx_sh;
    tx_par_n    = tx_par;
    tx_pop      = 1'b0;
    if (tick && tx_state != TX_IDLE) tx_tcnt_n = tx_tcnt + 4'd1;
    case (tx_state)
      TX_IDLE: begin
        if (!tx_have) begin
          if (tx_can_pop) begin
            tx_pop    = 1'b1;
            tx_sh_n   = tx_head;
            tx_have_n = 1'b1;
          end
        end else if (tick) begin
          tx_state_n  = TX_START;
          tx_tcnt_n   = '0;
          tx_have_n   = 1'b0;
          tx_par_en_n = parity_en;
          tx_par_n    = par_of(tx_sh, parity_odd);
          lb_n        = loopback;
        end
      end
      TX_START: if (tx_end) begin
        tx_state_n = TX_DATA;
        tx_bit_n   = '0;
      end
      TX_DATA: if (tx_end) begin
        tx_sh_n = tx_sh >> 1;
        if (tx_bit == 3'(DATA_W-1)) tx_state_n = tx_par_en ? TX_PARITY : TX_STOP;
        else                        tx_bit_n   = tx_bit + 3'd1;
      end
      TX_PARITY: if (tx_end) tx_state_n = TX_STOP;
      TX_STOP: if (tx_end) begin
        // Chain straight into the next start bit so frames run back-to-back.
        if (tx_can_pop) begin
          tx_pop      = 1'b1;
          tx_sh_n     = tx_head;
          tx_state_n  = TX_START;
          tx_par_en_n = parity_en;
          tx_par_n    = par_of(tx_head, parity_odd);
          lb_n        = loopback;
        end else begin
          tx_state_n = TX_IDLE;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_comb begin
    case (tx_state)
      TX_START:  txd = 1'b0;
      TX_DATA:   txd = tx_sh[0];
      TX_PARITY: txd = tx_par;
      default:   txd = 1'b1;
    endcase
  end

  // RX line select and synchroniser (p2 holds the previous sample for edge detect)
  logic rx_src, rx_sync_p0, rx_sync_p1, rx_sync_p2;
  assign rx_src = ((tx_state != TX_IDLE) ? lb_q : loopback) ? txd : rxd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
      rx_sync_p2 <= 1'b1;
    end else begin
      rx_sync_p0 <= rx_src;
      rx_sync_p1 <= rx_sync_p0;
      rx_sync_p2 <= rx_sync_p1;
    end
  end

  // RX FIFO
  logic [DATA_W-1:0] rx_mem [DEPTH];
  logic [AW-1:0]     rx_wr, rx_rd;
  logic [LW-1:0]     rx_cnt;
  logic              rx_push, rx_pop, rx_full;
  logic [DATA_W-1:0] rx_sh, rx_sh_n;

  assign rx_valid = (rx_cnt != '0);
  assign rx_pop   = rx_valid && rx_ready;
  assign rx_full  = (rx_cnt == LW'(DEPTH)) && !rx_pop;
  assign rx_level = rx_cnt;
  assign rx_data  = rx_valid ? rx_mem[rx_rd] : '0;

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr] <= rx_sh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + AW'(1);
      if (rx_pop)  rx_rd <= rx_rd + AW'(1);
      if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + LW'(1);
      else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - LW'(1);
    end
  end

  // RX engine
  rx_state_t  rx_state, rx_state_n;
  logic [3:0] rx_tcnt, rx_tcnt_n;
  logic [2:0] rx_bit, rx_bit_n;
  logic       rx_par_en, rx_par_en_n, rx_odd, rx_odd_n, rx_pbit, rx_pbit_n;
  logic       rx_line, rx_fall, rx_mid, rx_end;

  assign rx_line = rx_sync_p1;
  assign rx_fall = rx_sync_p2 && !rx_sync_p1;
  assign rx_mid  = tick && (rx_tcnt == 4'd8);
  assign rx_end  = tick && (rx_tcnt == 4'd15);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state  <= RX_IDLE;
      rx_tcnt   <= '0;
      rx_bit    <= '0;
      rx_par_en <= 1'b0;
      rx_odd    <= 1'b0;
    end else begin
      rx_state  <= rx_state_n;
      rx_tcnt   <= rx_tcnt_n;
      rx_bit    <= rx_bit_n;
      rx_par_en <= rx_par_en_n;
      rx_odd    <= rx_odd_n;
    end
  end

  always_ff @(posedge clk) begin
    rx_sh   <= rx_sh_n;
    rx_pbit <= rx_pbit_n;
  end

  always_comb begin
    rx_state_n    = rx_state;
    rx_tcnt_n     = rx_tcnt;
    rx_bit_n      = rx_bit;
    rx_par_en_n   = rx_par_en;
    rx_odd_n      = rx_odd;
    rx_sh_n       = rx_sh;
    rx_pbit_n     = rx_pbit;
    rx_push       = 1'b0;
    rx_parity_err = 1'b0;
    rx_frame_err  = 1'b0;
    rx_overrun    = 1'b0;
    if (tick && rx_state != RX_IDLE && rx_state != RX_WAIT_HIGH) rx_tcnt_n = rx_tcnt + 4'd1;
    case (rx_state)
      RX_IDLE: if (rx_fall) begin
        rx_state_n  = RX_START;
        rx_tcnt_n   = '0;
        rx_par_en_n = parity_en;
        rx_odd_n    = parity_odd;
      end
      RX_START: begin
        if (rx_mid && rx_line) rx_state_n = RX_IDLE;
        else if (rx_end) begin
          rx_state_n = RX_DATA;
          rx_bit_n   = '0;
        end
      end
      RX_DATA: begin
        if (rx_mid) rx_sh_n = {rx_line, rx_sh[DATA_W-1:1]};
        if (rx_end) begin
          if (rx_bit == 3'(DATA_W-1)) rx_state_n = rx_par_en ? RX_PARITY : RX_STOP;
          else                        rx_bit_n   = rx_bit + 3'd1;
        end
      end
      RX_PARITY: begin
        if (rx_mid) rx_pbit_n = rx_line;
        if (rx_end) rx_state_n = RX_STOP;
      end
      RX_STOP: if (rx_mid) begin
        // Leaving at mid-stop lets the next start edge be caught without slip.
        rx_state_n = RX_IDLE;
        if (!rx_line) begin
          rx_frame_err = 1'b1;
          rx_state_n   = RX_WAIT_HIGH;
        end else if (rx_par_en && (rx_pbit != par_of(rx_sh, rx_odd))) rx_parity_err = 1'b1;
        else if (rx_full) rx_overrun = 1'b1;
        else              rx_push    = 1'b1;
      end
      RX_WAIT_HIGH: if (rx_line) rx_state_n = RX_IDLE;
      default: rx_state_n = RX_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl: serial timing, FIFO limits, parity,
// framing, overrun, glitch rejection and mid-frame reset.
module tb_uart_fifo_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] baud_div = 16'd27;
  logic        parity_en = 1'b0, parity_odd = 1'b0, loopback = 1'b1, tx_en = 1'b1;
  logic        rxd = 1'b1;
  logic        txd;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_valid = 1'b0, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready = 1'b0;
  logic [4:0]  tx_level, rx_level;
  logic        rx_parity_err, rx_frame_err, rx_overrun;

  int checks = 0;
  int failures = 0;
  int pe_cnt = 0, fe_cnt = 0, ov_cnt = 0;
  int pe0, fe0, ov0;
  logic [7:0] exp_q[$];
  bit ok;

  uart_fifo_ctrl dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .parity_en(parity_en),
    .parity_odd(parity_odd), .loopback(loopback), .tx_en(tx_en), .rxd(rxd),
    .txd(txd), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_level(tx_level), .rx_level(rx_level), .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_parity_err) pe_cnt++;
    if (rx_frame_err)  fe_cnt++;
    if (rx_overrun)    ov_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    pe0 = pe_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
  endtask

  task automatic wait_txd_low(output bit found);
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      cyc(1);
      if (txd == 1'b0) begin found = 1'b1; break; end
    end
  endtask

  task automatic push_wait(input logic [7:0] d);
    int g = 0;
    while (!tx_ready && g < 5000) begin cyc(1); g++; end
    check("push_ready", 32'(tx_ready), 32'd1);
    tx_data = d; tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic with_par, input logic pbit, input logic stopb);
    rxd = 1'b0; cyc(16);
    for (int i = 0; i < 8; i++) begin rxd = d[i]; cyc(16); end
    if (with_par) begin rxd = pbit; cyc(16); end
    rxd = stopb; cyc(16);
  endtask

  // Scoreboard drain: each word the DUT presents is popped and compared
  task automatic drain();
    int g = 0;
    rx_ready = 1'b1;
    while (exp_q.size() > 0 && g < 400) begin
      @(negedge clk);
      g++;
      if (rx_valid) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("rx_data", 32'(rx_data), 32'(e));
      end
    end
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
    rx_ready = 1'b0;
    check("drain_level", 32'(rx_level), 32'd0);
  endtask

  initial begin
    logic [7:0] v;
    cyc(3);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_levels", 32'({tx_level, rx_level}), 32'd0);
    check("rst_errs", 32'({rx_parity_err, rx_frame_err, rx_overrun}), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    rst = 1'b0;
    cyc(5);

    // Loopback frame at baud_div=27: 432 clk per bit
    snap();
    v = 8'hA5;
    tx_data = v; tx_valid = 1'b1; cyc(1); tx_valid = 1'b0;
    exp_q.push_back(v);
    wait_txd_low(ok);
    check("t1_start_seen", 32'(ok), 32'd1);
    cyc(431);
    check("t1_start_len", 32'(txd), 32'd0);
    cyc(1);
    check("t1_start_end", 32'(txd), 32'(v[0]));
    cyc(216);
    for (int k = 0; k < 8; k++) begin
      check("t1_bit", 32'(txd), 32'(v[k]));
      cyc(432);
    end
    check("t1_stop", 32'(txd), 32'd1);
    for (int i = 0; i < 2000 && !rx_valid; i++) cyc(1);
    check("t1_rx_data", 32'(rx_data), 32'hA5);
    check("t1_rx_level", 32'(rx_level), 32'd1);
    check("t1_errs", 32'((pe_cnt - pe0) + (fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);
    drain();
    baud_div = 16'd1;
    cyc(100);

    // TX FIFO fill to full, overflow word dropped, then back-to-back frames
    tx_en = 1'b0;
    snap();
    for (int i = 0; i < 17; i++) begin
      tx_data = 8'(i); tx_valid = 1'b1;
      cyc(1);
      if (i == 15) begin
        check("t2_level_full", 32'(tx_level), 32'd16);
        check("t2_ready_low", 32'(tx_ready), 32'd0);
      end
    end
    tx_valid = 1'b0;
    check("t2_level_after_drop", 32'(tx_level), 32'd16);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    tx_en = 1'b1;
    wait_txd_low(ok);
    check("t2_start_seen", 32'(ok), 32'd1);
    cyc(8);
    for (int k = 0; k < 16; k++) begin
      logic [9:0] obs, e;
      for (int b = 0; b < 10; b++) begin obs[b] = txd; cyc(16); end
      e = {1'b1, 8'(k), 1'b0};
      check("t2_frame", 32'(obs), 32'(e));
    end
    cyc(200);
    check("t2_rx_level", 32'(rx_level), 32'd16);
    check("t2_no_overrun", 32'(ov_cnt - ov0), 32'd0);
    check("t2_tx_level", 32'(tx_level), 32'd0);
    drain();

    // External rxd with odd parity: wrong then correct parity bit
    loopback = 1'b0; parity_en = 1'b1; parity_odd = 1'b1;
    cyc(5);
    snap();
    send_rx(8'h3C, 1'b1, 1'b0, 1'b1);
    cyc(20);
    check("t3_parity_pulse", 32'(pe_cnt - pe0), 32'd1);
    check("t3_other_errs", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);
    check("t3_no_push", 32'(rx_level), 32'd0);
    send_rx(8'h3C, 1'b1, 1'b1, 1'b1);
    cyc(20);
    check("t3_good_level", 32'(rx_level), 32'd1);
    check("t3_parity_once", 32'(pe_cnt - pe0), 32'd1);
    exp_q.push_back(8'h3C);
    drain();

    // Framing error followed by a break, then a good frame
    parity_en = 1'b0; parity_odd = 1'b0;
    snap();
    send_rx(8'h55, 1'b0, 1'b0, 1'b0);
    cyc(160);
    rxd = 1'b1;
    cyc(40);
    check("t4_frame_once", 32'(fe_cnt - fe0), 32'd1);
    check("t4_other_errs", 32'((pe_cnt - pe0) + (ov_cnt - ov0)), 32'd0);
    check("t4_no_push", 32'(rx_level), 32'd0);
    send_rx(8'h12, 1'b0, 1'b0, 1'b1);
    cyc(20);
    check("t4_good_level", 32'(rx_level), 32'd1);
    exp_q.push_back(8'h12);
    drain();

    // RX overrun: 17 loopback frames into a 16-deep RX FIFO
    loopback = 1'b1;
    cyc(5);
    snap();
    for (int i = 1; i <= 17; i++) push_wait(8'(i));
    cyc(3000);
    check("t5_rx_level", 32'(rx_level), 32'd16);
    check("t5_overrun_once", 32'(ov_cnt - ov0), 32'd1);
    check("t5_other_errs", 32'((pe_cnt - pe0) + (fe_cnt - fe0)), 32'd0);
    check("t5_head", 32'(rx_data), 32'h01);
    for (int i = 1; i <= 16; i++) exp_q.push_back(8'(i));
    drain();

    // Short low glitch on external rxd is rejected silently
    loopback = 1'b0;
    cyc(5);
    snap();
    rxd = 1'b0; cyc(5); rxd = 1'b1;
    cyc(100);
    check("t6_errs", 32'((pe_cnt - pe0) + (fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);
    check("t6_no_push", 32'(rx_level), 32'd0);

    // Reset during the third data bit of a transmitting frame
    loopback = 1'b1;
    cyc(5);
    push_wait(8'h77);
    cyc(300);
    check("t7_rx_pre", 32'(rx_level), 32'd1);
    push_wait(8'hF0);
    push_wait(8'h0F);
    wait_txd_low(ok);
    check("t7_start_seen", 32'(ok), 32'd1);
    cyc(16 + 32 + 8);
    check("t7_pre_txd", 32'(txd), 32'd0);
    check("t7_pre_tx_level", 32'(tx_level), 32'd1);
    rst = 1'b1;
    #1;
    check("t7_rst_txd", 32'(txd), 32'd1);
    check("t7_rst_levels", 32'({tx_level, rx_level}), 32'd0);
    cyc(2);
    rst = 1'b0;
    snap();
    ok = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cyc(1);
      if (txd != 1'b1) ok = 1'b0;
    end
    check("t7_idle_txd", 32'(ok), 32'd1);
    check("t7_post_levels", 32'({tx_level, rx_level}), 32'd0);
    check("t7_post_rx_valid", 32'(rx_valid), 32'd0);
    check("t7_post_errs", 32'((pe_cnt - pe0) + (fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);
    push_wait(8'h5A);
    cyc(300);
    check("t7_new_frame", 32'(rx_level), 32'd1);
    exp_q.push_back(8'h5A);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_fifo_ctrl.md
Name: uart_fifo_ctrl

Overview:
- Parametrised single-clock UART transceiver with integrated TX and RX FIFOs; next generation of the UART/FIFO top-level.
- Runtime baud divisor, data width 5..8, optional parity, internal loopback, and error reporting (parity, framing, overrun).
- Sits between the PC serial line (rxd/txd) and on-chip logic that exchanges words over valid/ready handshakes.

Parameters:
- DATA_W, 8, data bits per frame; legal range 5..8.
- DEPTH, 16, entries per FIFO; power of 2, minimum 2.
- DIV_W, 16, width of the baud_div input.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- baud_div  in  DIV_W  clk cycles per 1/16-bit tick; 0 is treated as 1
- parity_en  in  1  1 = parity bit present after the data bits
- parity_odd  in  1  1 = odd parity, 0 = even
- loopback  in  1  1 = RX samples internal txd; external rxd ignored
- tx_en  in  1  1 = TX engine may pop the TX FIFO
- rxd  in  1  serial input (asynchronous)
- txd  out  1  serial output
- tx_data  in  DATA_W  word to transmit
- tx_valid  in  1  push request
- tx_ready  out  1  TX FIFO not full
- rx_data  out  DATA_W  head of RX FIFO (first-word-fall-through)
- rx_valid  out  1  RX FIFO not empty
- rx_ready  in  1  pop request
- tx_level  out  $clog2(DEPTH+1)  TX FIFO occupancy
- rx_level  out  $clog2(DEPTH+1)  RX FIFO occupancy
- rx_parity_err  out  1  one-cycle pulse
- rx_frame_err  out  1  one-cycle pulse
- rx_overrun  out  1  one-cycle pulse

Behaviour:
- Reset values: txd=1; tx_ready=1; rx_valid=0; both levels=0; all error pulses=0; both FSMs IDLE; tick counter=0; rx_data=0.
- Tick generator: free-running counter emits a one-cycle tick every max(baud_div,1) clk. One bit period is 16 ticks. A baud_div change takes effect at the next counter wrap.
- FIFOs: push when valid&ready; pop when valid&ready. Simultaneous push and pop leaves the level unchanged. A push while full is ignored with no state change. Pointers are log2(DEPTH) bits and wrap naturally. rx_data reflects the head combinationally from registered storage.
- TX FSM: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when tx_en=1 and the TX FIFO is non-empty, pop the head into the shifter (level drops in the same cycle) and go to START on the next tick boundary.
  - Each state lasts 16 ticks. START drives txd=0.
  - DATA shifts LSB first for DATA_W bits.
  - PARITY runs only if parity_en=1 and drives XOR(data)^parity_odd.
  - STOP drives txd=1, then returns to IDLE; back-to-back frames have no extra idle gap.
  - parity_en, parity_odd and loopback are sampled at START and held for the whole frame.
- RX path:
  - The rxd source is txd when loopback=1, otherwise rxd.
  - The source passes through a 2-flop synchroniser.
- RX FSM: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: a falling edge moves to START and clears the sample-tick count.
  - START: sample at tick 8. If the line is high, treat it as a glitch and return to IDLE. Otherwise stay in START until tick 15, then go to DATA.
  - DATA/PARITY: sample each bit at tick 8, LSB first.
  - STOP, sampled at tick 8:
    - Stop=0: pulse rx_frame_err, discard the word, go to WAIT_HIGH.
    - Parity mismatch: pulse rx_parity_err, discard the word.
    - RX FIFO full: pulse rx_overrun, discard the word; existing contents are untouched.
    - Otherwise push the word.
    - In all stop cases except stop=0, go to IDLE. The pulse or push occurs in the cycle of the tick-8 sample.
  - WAIT_HIGH: return to IDLE only after the line is seen high, so a break condition produces exactly one rx_frame_err.
  - Parity and frame errors never push a word. Only one error pulse fires per frame; frame error takes priority over parity, and parity over overrun.
- A pop and an RX push in the same cycle while full: pop first, so the push succeeds and rx_overrun does not fire.
- Reset asserted mid-frame: txd goes to 1 asynchronously, any partial RX word is lost, and both FIFOs are emptied.

Test Plan:
- baud_div=27, loopback=1, parity off, push 0xA5: txd low for 432 clk, then bits 1,0,1,0,0,1,0,1 (432 clk each), stop high. rx_valid rises with rx_data=0xA5, rx_level=1.
- tx_en=0, push 17 words 0x00..0x10: tx_level=16 and tx_ready=0 after the 16th; word 0x10 dropped. Set tx_en=1: txd emits 0x00..0x0F in order, no idle gap between frames.
- parity_en=1, parity_odd=1, external rxd frame 0x3C with parity bit 0 (wrong): one rx_parity_err pulse, rx_level stays 0. Repeat with parity bit 1: 0x3C received.
- External rxd frame 0x55 with stop bit 0, then line held low 10 bit times: exactly one rx_frame_err pulse, no push. The next valid frame 0x12 after the line returns high is received.
- rx_ready=0, loopback, send 17 words 0x01..0x11: rx_level=16, one rx_overrun on the 17th frame, head still 0x01.
- 0.3-bit low glitch on rxd: no reception, no error pulse.
- Reset mid-frame: assert rst during the 3rd TX data bit, so txd=1 in the same cycle. After release, tx_level=0, rx_level=0 and the FSMs are idle.
